hazard_forward_unit: RTL
========================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter AW, default 5: register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, legal 1..3: bubble cycles inserted per load-use hazard.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports id_ra, id_rb  in  AW  source registers of the instruction in ID.
REQ-006 SHALL have port id_mb  in  1  B operand is an immediate; B forwarding is suppressed.
REQ-007 SHALL have ports id_valid, id_we, id_is_load  in  1 each  ID slot valid, writes rd, is a load.
REQ-008 SHALL have port id_rd  in  AW  destination register of the instruction in ID.
REQ-009 SHALL have port ex_flush  in  1  taken branch/jump resolved in EX.
REQ-010 SHALL have port stall  out  1  hold PC and IF/ID; EX receives a bubble.
REQ-011 SHALL have ports a_sel, b_sel  out  2 each  EX operand select: 00 regfile, 01 MEM result, 10 WB result; 11 never driven.

Function
REQ-012 SHALL track three internal slots EX, MEM, WB, each holding {valid, we, is_load, rd}; on each non-stall edge ID->EX->MEM->WB, and the oldest WB is discarded.
REQ-013 SHALL insert a bubble (valid=0) into EX on any edge with stall=1 or ex_flush=1; MEM and WB always advance.
REQ-014 A slot "matches" register r iff valid & we & rd==r.
REQ-015 SHALL register a_sel at the ID->EX edge: 01 if the current EX slot matches id_ra, else 10 if the current MEM slot matches id_ra, else 00; a_sel is thus valid throughout the instruction's EX cycle.
REQ-016 SHALL compute b_sel identically with id_rb, forced to 00 when id_mb=1.
REQ-017 SHALL register a_sel=b_sel=00 whenever a bubble enters EX.
REQ-018 MEM priority over WB on a double match (most recent producer wins).
REQ-019 Load-use hazard = id_valid & EX slot is_load & EX slot matches id_ra, or matches id_rb with id_mb=0.
REQ-020 SHALL implement FSM {RUN, STALL} with down-counter cnt of width 2.
REQ-021 RUN: stall = hazard & ~ex_flush (combinational); on hazard & ~ex_flush, next state STALL if LOAD_LAT>1 (cnt <= LOAD_LAT-2), else remain RUN.
REQ-022 STALL: stall=1; cnt decrements each cycle; at cnt==0 next state RUN.
REQ-023 Re-evaluation after stall: forwarding for the held instruction SHALL use the slots current on the edge it actually enters EX (load then in MEM -> 10, or past WB -> 00).
REQ-024 ex_flush in any state SHALL force next state RUN, clear cnt, deassert stall combinationally, and bubble EX; flush wins over a simultaneous hazard.
REQ-025 id_valid=0 SHALL never raise a hazard, and enters EX as a bubble.

Reset
REQ-026 rst=0 SHALL immediately clear all slot valid bits, rd fields, cnt, a_sel, b_sel to 0, and FSM to RUN; stall reads 0.
REQ-027 Reset asserted mid-STALL SHALL abort the stall; the first edge after release behaves as RUN with empty pipeline.

Configuration
REQ-028 Macro FWD_X0_GUARD_EN: when defined, a slot with rd==0 SHALL never match (no forwarding or stall on x0); when undefined, register 0 is compared like any other register.

Verification
REQ-029 add x5 then sub x6,x5,x7 back-to-back -> a_sel=01, b_sel=00 in sub's EX cycle.
REQ-030 add x5; nop; or x8,x9,x5 -> b_sel=10 in or's EX cycle; with id_mb=1 -> b_sel=00.
REQ-031 LOAD_LAT=1: lw x3; add x4,x3,x3 -> stall=1 one cycle, one bubble, then a_sel=b_sel=10; LOAD_LAT=3 -> stall 3 cycles, then a_sel=b_sel=00.
REQ-032 lw x3 with add x4,x3,x1 in ID and ex_flush=1 same cycle -> stall=0, EX bubble, FSM RUN next cycle.
REQ-033 LOAD_LAT=3, rst pulsed low during 2nd stall cycle -> stall=0 immediately, all selects 00, no residual forwarding after release.
REQ-034 add x0,x1,x2 then sub x6,x0,x0 -> a_sel=b_sel=00 with FWD_X0_GUARD_EN, 01/01 without.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection and EX operand-forwarding control for an in-order pipeline.
// Define FWD_X0_GUARD_EN to stop register 0 from ever forwarding or raising a stall.

module hazard_forward_unit #(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] id_ra,
    input  logic [AW-1:0] id_rb,
    input  logic          id_mb,
    input  logic          id_valid,
    input  logic          id_we,
    input  logic          id_is_load,
    input  logic [AW-1:0] id_rd,
    input  logic          ex_flush,
    output logic          stall,
    output logic [1:0]    a_sel,
    output logic [1:0]    b_sel
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    localparam bit         MULTI_BUBBLE = (LOAD_LAT > 1);
    localparam logic [1:0] CNT_INIT     = MULTI_BUBBLE ? 2'(LOAD_LAT - 2) : 2'd0;

    typedef enum logic {RUN, STALL} state_t;

    typedef struct packed {
        logic          valid;
        logic          we;
        logic          is_load;
        logic [AW-1:0] rd;
    } slot_t;

    // An instruction leaving MEM is only written back; no forwarding or hazard
    // decision reads the WB slot, so only EX and MEM occupancy is held here.
    slot_t         ex_slot;
    slot_t         ex_next;
    logic          mem_valid;
    logic          mem_we;
    logic [AW-1:0] mem_rd;

    state_t        state;
    state_t        state_next;
    logic [1:0]    cnt;
    logic [1:0]    cnt_next;

    logic          hazard;
    logic          bubble_in;
    logic [1:0]    a_next;
    logic [1:0]    b_next;

    function automatic logic writes_reg(input logic          valid,
                                        input logic          we,
                                        input logic [AW-1:0] rd,
                                        input logic [AW-1:0] r);
`ifdef FWD_X0_GUARD_EN
        return valid & we & (rd == r) & (rd != '0);
`else
        return valid & we & (rd == r);
`endif
    endfunction

    function automatic logic [1:0] pick_src(input logic [AW-1:0] r);
        // The older producer only wins when the younger one does not write r.
        if (writes_reg(ex_slot.valid, ex_slot.we, ex_slot.rd, r))
            return SEL_MEM;
        else if (writes_reg(mem_valid, mem_we, mem_rd, r))
            return SEL_WB;
        else
            return SEL_RF;
    endfunction

    always_comb begin
        hazard = id_valid & ex_slot.is_load &
                 (writes_reg(ex_slot.valid, ex_slot.we, ex_slot.rd, id_ra) |
                  (writes_reg(ex_slot.valid, ex_slot.we, ex_slot.rd, id_rb) & ~id_mb));
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            // NOTE: all clocked state uses <= so every flop samples pre-edge values.
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        state_next = state;
        cnt_next   = cnt;
        if (ex_flush) begin
            state_next = RUN;
            cnt_next   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard && MULTI_BUBBLE) begin
                        state_next = STALL;
                        cnt_next   = CNT_INIT;
                    end
                end
                STALL: begin
                    if (cnt == 2'd0) state_next = RUN;
                    else             cnt_next   = cnt - 2'd1;
                end
            endcase
        end
    end

    // FSM: output logic; a flush always releases the front end.
    always_comb begin
        stall = 1'b0;
        if (!ex_flush) begin
            case (state)
                RUN:   stall = hazard;
                STALL: stall = 1'b1;
            endcase
        end
    end

    always_comb begin
        bubble_in = stall | ex_flush | ~id_valid;
        ex_next   = '0;
        a_next    = SEL_RF;
        b_next    = SEL_RF;
        if (!bubble_in) begin
            ex_next = '{valid: 1'b1, we: id_we, is_load: id_is_load, rd: id_rd};
            a_next  = pick_src(id_ra);
            b_next  = id_mb ? SEL_RF : pick_src(id_rb);
        end
    end

    // NOTE: these are a handful of control flops, so all of them take the async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_slot   <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_rd    <= '0;
            a_sel     <= SEL_RF;
            b_sel     <= SEL_RF;
        end else begin
            mem_valid <= ex_slot.valid;
            mem_we    <= ex_slot.we;
            mem_rd    <= ex_slot.rd;
            ex_slot   <= ex_next;
            a_sel     <= a_next;
            b_sel     <= b_next;
        end
    end

endmodule
